// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: key decode, step scheduling, direction rules, score and game state.
// Optional macro SNAKE_SPEEDUP_EN shortens the step period every FOODS_PER_LVL foods.
module snake_game_ctrl #(
    parameter int unsigned STEP_BASE     = 10_000_000,
    parameter int unsigned STEP_MIN      = 2_500_000,
    parameter int unsigned STEP_DEC      = 500_000,
    parameter int unsigned FOODS_PER_LVL = 4,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_w,
    input  logic               key_a,
    input  logic               key_s,
    input  logic               key_d,
    input  logic               collide,
    input  logic               food_eaten,
    output logic               step,
    output logic [2:0]         dir,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);

    localparam int unsigned CNT_W = $clog2(STEP_BASE + 1);

    localparam logic [2:0] DIR_IDLE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;
    localparam logic [2:0] DIR_OVER  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t             st, st_nxt;
    logic [2:0]         dir_nxt, next_dir, next_dir_nxt;
    logic               step_nxt, grow_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   cur_period;
    logic               key_any;
    logic [2:0]         key_code;
    logic [2:0]         dir_rev;
    logic               terminal;

`ifdef SNAKE_SPEEDUP_EN
    localparam int unsigned FC_W = (FOODS_PER_LVL > 1) ? $clog2(FOODS_PER_LVL) : 1;

    // period is the pending value; cur_period is latched at each wrap so intervals never truncate
    logic [CNT_W-1:0] period, period_nxt, cur_period_nxt;
    logic [FC_W-1:0]  food_cnt, food_cnt_nxt;
`else
    assign cur_period = CNT_W'(STEP_BASE);
`endif

    assign state    = st;
    assign terminal = (cnt == cur_period - CNT_W'(1));

    // Priority key decode W > A > S > D and reverse-direction lookup
    always_comb begin
        key_any  = key_w | key_a | key_s | key_d;
        key_code = DIR_IDLE;
        if (key_w)      key_code = DIR_UP;
        else if (key_a) key_code = DIR_LEFT;
        else if (key_s) key_code = DIR_DOWN;
        else if (key_d) key_code = DIR_RIGHT;

        case (dir)
            DIR_UP:    dir_rev = DIR_DOWN;
            DIR_LEFT:  dir_rev = DIR_RIGHT;
            DIR_DOWN:  dir_rev = DIR_UP;
            DIR_RIGHT: dir_rev = DIR_LEFT;
            default:   dir_rev = DIR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    // Next-state and datapath update
    always_comb begin
        st_nxt       = st;
        dir_nxt      = dir;
        next_dir_nxt = next_dir;
        step_nxt     = 1'b0;
        grow_nxt     = 1'b0;
        score_nxt    = score;
        cnt_nxt      = cnt;
`ifdef SNAKE_SPEEDUP_EN
        period_nxt     = period;
        cur_period_nxt = cur_period;
        food_cnt_nxt   = food_cnt;
`endif
        case (st)
            ST_IDLE: begin
                if (key_any) begin
                    st_nxt       = ST_PLAY;
                    dir_nxt      = key_code;
                    next_dir_nxt = key_code;
                    cnt_nxt      = '0;
`ifdef SNAKE_SPEEDUP_EN
                    cur_period_nxt = period;
`endif
                end
            end
            ST_PLAY: begin
                if (collide) begin
                    st_nxt  = ST_OVER;
                    dir_nxt = DIR_OVER;
                end else begin
                    if (key_any && key_code != dir && key_code != dir_rev)
                        next_dir_nxt = key_code;
                    if (food_eaten) begin
                        grow_nxt = 1'b1;
                        if (score != '1) score_nxt = score + SCORE_W'(1);
`ifdef SNAKE_SPEEDUP_EN
                        if (food_cnt == FC_W'(FOODS_PER_LVL - 1)) begin
                            food_cnt_nxt = '0;
                            period_nxt   = (32'(period) >= STEP_MIN + STEP_DEC)
                                         ? period - CNT_W'(STEP_DEC) : CNT_W'(STEP_MIN);
                        end else begin
                            food_cnt_nxt = food_cnt + FC_W'(1);
                        end
`endif
                    end
                    if (terminal) begin
                        step_nxt = 1'b1;
                        cnt_nxt  = '0;
                        dir_nxt  = next_dir;
`ifdef SNAKE_SPEEDUP_EN
                        cur_period_nxt = period_nxt;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (key_any) begin
                    st_nxt       = ST_IDLE;
                    score_nxt    = '0;
                    dir_nxt      = DIR_IDLE;
                    next_dir_nxt = DIR_IDLE;
`ifdef SNAKE_SPEEDUP_EN
                    period_nxt   = CNT_W'(STEP_BASE);
                    food_cnt_nxt = '0;
`endif
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir      <= DIR_IDLE;
            next_dir <= DIR_IDLE;
            step     <= 1'b0;
            grow     <= 1'b0;
            score    <= '0;
            cnt      <= '0;
        end else begin
            dir      <= dir_nxt;
            next_dir <= next_dir_nxt;
            step     <= step_nxt;
            grow     <= grow_nxt;
            score    <= score_nxt;
            cnt      <= cnt_nxt;
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period     <= CNT_W'(STEP_BASE);
            cur_period <= CNT_W'(STEP_BASE);
            food_cnt   <= '0;
        end else begin
            period     <= period_nxt;
            cur_period <= cur_period_nxt;
            food_cnt   <= food_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a small step period; expectations follow SNAKE_SPEEDUP_EN.
module tb_snake_game_ctrl;

    localparam int unsigned STEP_BASE     = 20;
    localparam int unsigned STEP_MIN      = 8;
    localparam int unsigned STEP_DEC      = 4;
    localparam int unsigned FOODS_PER_LVL = 2;
    localparam int unsigned SCORE_W       = 4;

`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic               key_w, key_a, key_s, key_d;
    logic               collide;
    logic               food_eaten;
    logic               step;
    logic [2:0]         dir;
    logic               grow;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;

    int n_tests = 0;
    int n_fail  = 0;

    snake_game_ctrl #(
        .STEP_BASE    (STEP_BASE),
        .STEP_MIN     (STEP_MIN),
        .STEP_DEC     (STEP_DEC),
        .FOODS_PER_LVL(FOODS_PER_LVL),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_w     (key_w),
        .key_a     (key_a),
        .key_s     (key_s),
        .key_d     (key_d),
        .collide   (collide),
        .food_eaten(food_eaten),
        .step      (step),
        .dir       (dir),
        .grow      (grow),
        .score     (score),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles until step is seen high, or -1 after the bound expires
    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (step) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int cnt_steps;
    int exp_score;
    int exp_p;

    initial begin
        reset = 1'b0;
        {key_w, key_a, key_s, key_d} = 4'b0;
        collide    = 1'b0;
        food_eaten = 1'b0;

        tick();
        tick();
        check("rst_state", int'(state), 0);
        check("rst_dir",   int'(dir),   0);
        check("rst_step",  int'(step),  0);
        check("rst_grow",  int'(grow),  0);
        check("rst_score", int'(score), 0);
        reset = 1'b1;

        cnt_steps = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (step) cnt_steps++;
        end
        check("idle_no_step", cnt_steps, 0);
        check("idle_state", int'(state), 0);

        // Start game heading right
        key_d = 1'b1; tick(); key_d = 1'b0;
        check("start_state", int'(state), 1);
        check("start_dir",   int'(dir),   4);
        wait_step(n);
        check("first_step_lat", n, 20);
        tick();
        check("step_one_cycle", int'(step), 0);
        wait_step(n);
        check("second_interval", n + 1, 20);

        // A is reverse of right (rejected), W accepted; dir moves only at step
        key_a = 1'b1; tick(); key_a = 1'b0;
        key_w = 1'b1; tick(); key_w = 1'b0;
        check("dir_hold_before_step", int'(dir), 4);
        wait_step(n);
        check("third_interval", n + 2, 20);
        check("dir_up_at_step", int'(dir), 1);

        key_a = 1'b1; tick(); key_a = 1'b0;
        wait_step(n);
        check("dir_left", int'(dir), 2);
        key_w = 1'b1; key_s = 1'b1; tick(); key_w = 1'b0; key_s = 1'b0;
        wait_step(n);
        check("ws_prio_dir", int'(dir), 1);
        key_s = 1'b1; tick(); key_s = 1'b0;
        wait_step(n);
        check("reverse_ignored", int'(dir), 1);

        // Two foods in each of three intervals, then two quiet intervals
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                food_eaten = 1'b1; tick(); food_eaten = 1'b0;
                tick();
                food_eaten = 1'b1; tick(); food_eaten = 1'b0;
                wait_step(n);
                n = n + 3;
            end else begin
                wait_step(n);
            end
            case (k)
                0: exp_p = 20;
                1: exp_p = SPEEDUP ? 16 : 20;
                2: exp_p = SPEEDUP ? 12 : 20;
                default: exp_p = SPEEDUP ? 8 : 20;
            endcase
            check($sformatf("interval_%0d", k), n, exp_p);
        end
        check("score_after_6", int'(score), 6);

        // Collide exactly on the terminal count
        exp_p = SPEEDUP ? 8 : 20;
        cnt_steps = 0;
        for (int i = 0; i < exp_p - 1; i++) begin
            tick();
            if (step) cnt_steps++;
        end
        check("pre_collide_no_step", cnt_steps, 0);
        collide = 1'b1; tick(); collide = 1'b0;
        check("collide_no_step", int'(step),  0);
        check("collide_state",   int'(state), 2);
        check("collide_dir",     int'(dir),   5);
        cnt_steps = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (step || grow) cnt_steps++;
        end
        check("over_quiet", cnt_steps, 0);
        check("over_score_held", int'(score), 6);

        key_s = 1'b1; tick(); key_s = 1'b0;
        check("over_idle_state", int'(state), 0);
        check("over_idle_score", int'(score), 0);
        check("over_idle_dir",   int'(dir),   0);

        // Restart and saturate the score
        key_w = 1'b1; tick(); key_w = 1'b0;
        check("restart_dir", int'(dir), 1);
        exp_score = 0;
        for (int i = 0; i < 17; i++) begin
            food_eaten = 1'b1; tick(); food_eaten = 1'b0;
            if (exp_score < 15) exp_score++;
            check($sformatf("grow_%0d", i), int'(grow), 1);
            check($sformatf("score_%0d", i), int'(score), exp_score);
            tick();
            check($sformatf("grow_low_%0d", i), int'(grow), 0);
        end
        check("score_sat", int'(score), 15);

        // Asynchronous reset mid-play, between clock edges
        food_eaten = 1'b1; tick(); food_eaten = 1'b0;
        check("grow_before_rst", int'(grow), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_dir",   int'(dir),   0);
        check("async_score", int'(score), 0);
        check("async_grow",  int'(grow),  0);
        check("async_step",  int'(step),  0);
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game sequencer for the snake design. Turns debounced WASD key pulses, the body's collision flag and a food-eaten pulse into a one-cycle step pulse, a committed direction code and a score. It sits between the debounce stage and the snake body/renderer, and replaces free-running clock division and bare direction latching with one scheduled, rule-checked source of movement. The direction code matches the existing encoding, including code 5 = game over, which turns the display blue.

## Interface
Parameters:
- STEP_BASE, 10_000_000 — clk cycles per step at game start (10 Hz at 100 MHz)
- STEP_MIN, 2_500_000 — floor on the step period
- STEP_DEC, 500_000 — period reduction per speed-up
- FOODS_PER_LVL, 4 — foods eaten per speed-up
- SCORE_W, 8 — score width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_w, key_a, key_s, key_d  in  1 each  debounced single-cycle key pulses
- collide  in  1  level; head hit wall or body
- food_eaten  in  1  single-cycle pulse from snake body
- step  out  1  one-cycle move strobe to snake body
- dir  out  3  0 idle, 1 up, 2 left, 3 down, 4 right, 5 game over
- grow  out  1  one-cycle pulse; body appends a segment
- score  out  SCORE_W  foods eaten, saturating
- state  out  2  0 IDLE, 1 PLAY, 2 OVER

## Operation
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, dir=0, next_dir=0
  - step=0, grow=0, score=0
  - period=STEP_BASE, step counter=0, food counter=0
- Key decode: when several keys pulse in the same cycle, priority is W>A>S>D. Key mapping: W→1, A→2, S→3, D→4.
- IDLE:
  - Any key → PLAY.
  - dir and next_dir take the key's code; counter cleared.
  - collide and food_eaten are ignored.
- PLAY, step scheduling:
  - Counter increments each cycle.
  - When counter == period-1: step=1 for one cycle, counter→0, dir←next_dir on the same edge.
- PLAY, key handling:
  - A key is accepted into next_dir unless it equals dir or is the reverse of dir (1↔3, 2↔4).
  - Rejected keys leave next_dir unchanged.
  - Multiple accepted keys between steps: the last one wins.
- PLAY, food:
  - food_eaten → score+1, saturating at all-ones.
  - grow=1 on the next cycle.
- PLAY, collide:
  - collide=1 sampled → OVER, dir=5, counter frozen.
  - No step is issued that cycle, even if the counter hits terminal.
  - collide has priority over step, key and food_eaten in the same cycle.
- OVER:
  - step=0, grow=0; score held.
  - Any key → IDLE: score=0, dir=0, next_dir=0, period=STEP_BASE, food counter=0.
- Unused state encoding 3 → IDLE on the next edge.

## Timing
- step and grow are registered, exactly one cycle wide, never back-to-back from a single event.
- dir changes only on the edge that raises step (PLAY), or on the IDLE→PLAY, PLAY→OVER and OVER→IDLE transitions.
- Step latency:
  - First step arrives STEP_BASE cycles after the IDLE→PLAY edge.
  - Subsequent steps arrive every `period` cycles.
- food_eaten at edge n: score updates at edge n+1, grow is high during cycle n+1.
- collide at edge n: state=OVER and dir=5 visible after edge n+1.
- A period change takes effect from the next counter wrap; the current interval is not truncated.

## Configuration
- SNAKE_SPEEDUP_EN defined:
  - Every FOODS_PER_LVL accepted food_eaten pulses, period ← max(period−STEP_DEC, STEP_MIN).
  - The food counter wraps to 0 on each speed-up.
- SNAKE_SPEEDUP_EN undefined:
  - period is constant STEP_BASE.
  - The food counter is not built.
  - Score and grow behave identically.

## Test plan
Bench parameters: STEP_BASE=20, STEP_MIN=8, STEP_DEC=4, FOODS_PER_LVL=2, SCORE_W=4.
- Reset then key_d pulse → state=1, dir=4; step high exactly 20 cycles later, then every 20 cycles; no step while in IDLE.
- dir=4, pulse key_a then key_w before the next step → a is rejected, w is accepted; dir becomes 1 on the next step edge and not before.
- key_w and key_s pulse in the same cycle with dir=2 → next_dir=1; then key_s alone at dir=1 → ignored.
- 17 food_eaten pulses → score saturates at 15; grow pulses 17 times, each one cycle after its food pulse.
- SNAKE_SPEEDUP_EN defined, 6 foods → step interval goes 20→16→12→8, then stays 8; undefined → stays 20.
- collide in the same cycle as a terminal count → no step, dir=5, state=2. Key pulse → state=0, score=0, dir=0. Asserting reset mid-PLAY clears all outputs immediately, without waiting for a clk edge.
